// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus-cycle generator.
//   state_t            : transaction FSM states (3-bit encoding)
//   RTC_T_SET/STB/HOLD : default setup / strobe / hold dwell, in cycles
//   RTC_RD / RTC_WR    : values of the rw direction input
//   dwell()            : cycles spent in a given state for a timing set
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SET,
    ST_A_STB,
    ST_A_HOLD,
    ST_D_SET,
    ST_D_STB,
    ST_D_HOLD,
    ST_DONE
  } state_t;

  localparam int unsigned RTC_T_SET  = 2;
  localparam int unsigned RTC_T_STB  = 8;
  localparam int unsigned RTC_T_HOLD = 2;

  localparam logic RTC_RD = 1'b1;
  localparam logic RTC_WR = 1'b0;

  function automatic int unsigned dwell(input state_t s, input int unsigned t_set,
                                        input int unsigned t_stb, input int unsigned t_hold);
    case (s)
      ST_A_SET,  ST_D_SET:  return t_set;
      ST_A_STB,  ST_D_STB:  return t_stb;
      ST_A_HOLD, ST_D_HOLD: return t_hold;
      default:              return 1;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// phase_timer: loadable down-counter timing one FSM state's dwell.
//   clk, reset : clock, asynchronous active-low reset
//   load       : load value (dwell - 1) into the counter
//   value      : reload value
//   expired    : counter has reached zero (last cycle of the dwell)
module phase_timer #(
  parameter int unsigned MAX = 8,
  localparam int unsigned W  = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: two-phase (address, then data) bus-cycle generator for the
// RTC chip's multiplexed A/D bus.
//   clk, reset          : clock, asynchronous active-low reset
//   start, rw           : request pulse (sampled in IDLE), 1 = read / 0 = write
//   addr, wdata         : register address and write datum, latched on start
//   ad_in               : bus value from the pad
//   ad_out, ad_oe       : bus drive value and pad output enable
//   cs_n, ad_sel        : chip select (low), 0 = address / 1 = data phase
//   wr_n, rd_n          : write / read strobes, active low
//   rdata               : last byte read
//   busy, done          : transaction in progress, one-cycle completion pulse
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SET  = RTC_T_SET,
  parameter int unsigned T_STB  = RTC_T_STB,
  parameter int unsigned T_HOLD = RTC_T_HOLD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       ad_sel,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);

  localparam int unsigned T_MAX0 = (T_SET > T_STB) ? T_SET : T_STB;
  localparam int unsigned T_MAX  = (T_MAX0 > T_HOLD) ? T_MAX0 : T_HOLD;
  localparam int unsigned TW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  state_t          state, next_state;
  logic            expired;
  logic            tmr_load;
  logic [TW-1:0]   tmr_value;
  logic [7:0]      addr_q, wdata_q;
  logic            rw_q;
  logic [7:0]      op_addr, op_wdata;
  logic            op_rw;

  logic [7:0]      ad_out_d;
  logic            ad_oe_d, cs_n_d, ad_sel_d, wr_n_d, rd_n_d, busy_d, done_d;

  phase_timer #(.MAX(T_MAX)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (expired)
  );

  // Outputs are registered from next_state, so on the accepting edge the
  // request must come straight from the inputs rather than the latches.
  assign op_addr  = (state == ST_IDLE) ? addr  : addr_q;
  assign op_wdata = (state == ST_IDLE) ? wdata : wdata_q;
  assign op_rw    = (state == ST_IDLE) ? rw    : rw_q;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start)   next_state = ST_A_SET;
      ST_A_SET:  if (expired) next_state = ST_A_STB;
      ST_A_STB:  if (expired) next_state = ST_A_HOLD;
      ST_A_HOLD: if (expired) next_state = ST_D_SET;
      ST_D_SET:  if (expired) next_state = ST_D_STB;
      ST_D_STB:  if (expired) next_state = ST_D_HOLD;
      ST_D_HOLD: if (expired) next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  assign tmr_load  = (next_state != state);
  assign tmr_value = TW'(dwell(next_state, T_SET, T_STB, T_HOLD) - 1);

  always_comb begin
    ad_out_d = '0;
    ad_oe_d  = 1'b0;
    cs_n_d   = 1'b1;
    ad_sel_d = 1'b0;
    wr_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (next_state)
      ST_A_SET, ST_A_STB, ST_A_HOLD: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = op_addr;
        busy_d   = 1'b1;
        wr_n_d   = (next_state != ST_A_STB);
      end
      ST_D_SET, ST_D_STB, ST_D_HOLD: begin
        cs_n_d   = 1'b0;
        ad_sel_d = 1'b1;
        busy_d   = 1'b1;
        if (op_rw == RTC_WR) begin
          ad_oe_d  = 1'b1;
          ad_out_d = op_wdata;
          wr_n_d   = (next_state != ST_D_STB);
        end else begin
          rd_n_d   = (next_state != ST_D_STB);
        end
      end
      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= RTC_WR;
      rdata   <= '0;
      ad_out  <= '0;
      ad_oe   <= 1'b0;
      cs_n    <= 1'b1;
      ad_sel  <= 1'b0;
      wr_n    <= 1'b1;
      rd_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state  <= next_state;
      ad_out <= ad_out_d;
      ad_oe  <= ad_oe_d;
      cs_n   <= cs_n_d;
      ad_sel <= ad_sel_d;
      wr_n   <= wr_n_d;
      rd_n   <= rd_n_d;
      busy   <= busy_d;
      done   <= done_d;
      if (state == ST_IDLE && start) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        rw_q    <= rw;
      end
      if (state == ST_D_STB && expired && rw_q == RTC_RD) begin
        rdata <= ad_in;
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed self-checking bench for rtc_bus_ctrl with default timing
// (2/8/2): every transaction is checked cycle by cycle against a timeline
// of A_SET 1-2, A_STB 3-10, A_HOLD 11-12, D_SET 13-14, D_STB 15-22,
// D_HOLD 23-24, DONE 25, IDLE 26 (cycles counted after the start edge).
module tb_rtc_bus_ctrl;
  import rtc_bus_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       rw = RTC_WR;
  logic [7:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] ad_in = '0;
  logic [7:0] ad_out;
  logic       ad_oe, cs_n, ad_sel, wr_n, rd_n, busy, done;
  logic [7:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_rdata = 8'h00;

  always #5 clk = ~clk;

  rtc_bus_ctrl #(.T_SET(2), .T_STB(8), .T_HOLD(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .rw     (rw),
    .addr   (addr),
    .wdata  (wdata),
    .ad_in  (ad_in),
    .ad_out (ad_out),
    .ad_oe  (ad_oe),
    .cs_n   (cs_n),
    .ad_sel (ad_sel),
    .wr_n   (wr_n),
    .rd_n   (rd_n),
    .rdata  (rdata),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bus-level invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      check("strobe_overlap", 32'(!wr_n && !rd_n), 32'd0);
      check("oe_during_rd",   32'(ad_oe && !rd_n), 32'd0);
    end
  end

  // Called in an IDLE cycle, #1 after an edge. Returns in the first IDLE
  // cycle after DONE so the next call starts back-to-back.
  task automatic run_txn(input logic r, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] rv, input bit poke);
    logic a_ph, d_ph, a_stb, d_stb;
    logic [7:0] e_out;
    rw = r; addr = a; wdata = d; start = 1'b1;
    for (int cyc = 1; cyc <= 26; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0; addr = ~a; wdata = ~d; rw = ~r;
      if (poke && (cyc == 5 || cyc == 24 || cyc == 25)) begin
        start = 1'b1; addr = 8'h99;
      end
      ad_in = (cyc >= 15 && cyc <= 22) ? rv : ~rv;
      a_ph  = (cyc <= 12);
      d_ph  = (cyc >= 13 && cyc <= 24);
      a_stb = (cyc >= 3 && cyc <= 10);
      d_stb = (cyc >= 15 && cyc <= 22);
      e_out = a_ph ? a : ((d_ph && !r) ? d : 8'h00);
      check($sformatf("cs_n[%0d]", cyc),   32'(cs_n),   32'(!(a_ph || d_ph)));
      check($sformatf("ad_sel[%0d]", cyc), 32'(ad_sel), 32'(d_ph));
      check($sformatf("wr_n[%0d]", cyc),   32'(wr_n),   32'(!(a_stb || (d_stb && !r))));
      check($sformatf("rd_n[%0d]", cyc),   32'(rd_n),   32'(!(d_stb && r)));
      check($sformatf("ad_oe[%0d]", cyc),  32'(ad_oe),  32'(a_ph || (d_ph && !r)));
      check($sformatf("ad_out[%0d]", cyc), 32'(ad_out), 32'(e_out));
      check($sformatf("busy[%0d]", cyc),   32'(busy),   32'(cyc <= 25));
      check($sformatf("done[%0d]", cyc),   32'(done),   32'(cyc == 25));
    end
    if (r) exp_rdata = rv;
    check("rdata", 32'(rdata), 32'(exp_rdata));
  endtask

  logic [7:0] init_a [13];
  logic [7:0] init_d [13];

  initial begin
    init_a = '{8'h02, 8'h02, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
               8'h41, 8'h42, 8'h43};
    init_d = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00};

    // Reset values
    #22;
    check("rst_cs_n",   32'(cs_n),   32'd1);
    check("rst_wr_n",   32'(wr_n),   32'd1);
    check("rst_rd_n",   32'(rd_n),   32'd1);
    check("rst_ad_sel", 32'(ad_sel), 32'd0);
    check("rst_ad_oe",  32'(ad_oe),  32'd0);
    check("rst_ad_out", 32'(ad_out), 32'h00);
    check("rst_rdata",  32'(rdata),  32'h00);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Write with ignored re-starts, then a read, then the init list, all back-to-back
    run_txn(RTC_WR, 8'h21, 8'h45, 8'h00, 1'b1);
    run_txn(RTC_RD, 8'h41, 8'h00, 8'h37, 1'b0);
    for (int i = 0; i < 13; i++) begin
      run_txn(RTC_WR, init_a[i], init_d[i], 8'h5A, 1'b0);
    end
    run_txn(RTC_RD, 8'h42, 8'h00, 8'hC3, 1'b0);

    // Abort in D_STB of a write
    rw = RTC_WR; addr = 8'h21; wdata = 8'h45; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("pre_abort_wr_n", 32'(wr_n), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("abort_cs_n",  32'(cs_n),  32'd1);
    check("abort_wr_n",  32'(wr_n),  32'd1);
    check("abort_ad_oe", 32'(ad_oe), 32'd0);
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_done",  32'(done),  32'd0);
    check("abort_rdata", 32'(rdata), 32'h00);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      check($sformatf("post_abort_done[%0d]", c), 32'(done), 32'd0);
      check($sformatf("post_abort_busy[%0d]", c), 32'(busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
